// File: rtl/rom_stream_reader.sv
// Read-side master for a 1-cycle-latency synchronous ROM: walks an address range on start
// and emits the words as a valid/ready stream with a last flag, buffered by a 4-entry FIFO.
module rom_stream_reader #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

    state_t                state;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued_count;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [1:0]            rd_valid;   // [0]: address on ROM, [1]: data on rom_dout
    logic [1:0]            rd_last;
    entry_t                fifo   [4];
    entry_t                fifo_n [4];
    logic [2:0]            fifo_count;
    logic [2:0]            fifo_count_n;
    logic [2:0]            in_flight;
    logic                  accept;
    logic                  issue;
    logic                  issue_last;
    logic                  push;
    logic                  pop;

    assign accept    = (state == IDLE) && start;
    assign in_flight = fifo_count + {2'b00, rd_valid[0]} + {2'b00, rd_valid[1]};
    assign push      = rd_valid[1];
    assign pop       = m_valid && m_ready;

    // The first read is issued on the accepting edge itself so the ROM sees base one cycle later.
    assign issue = (accept && (length != '0)) ||
                   ((state == RUN) && (issued_count < len_q) && (in_flight < 3'd4));
    assign issue_addr = accept ? base_addr : next_addr;
    assign issue_last = accept ? (length == CNT_ONE) : (issued_count == len_q - CNT_ONE);

    // Shift-down FIFO: entry 0 is the registered head; slots at or above fifo_count stay zero.
    // NOTE: always_comb starts from full defaults so no path leaves a variable unassigned (no latch).
    always_comb begin
        fifo_n       = fifo;
        fifo_count_n = fifo_count;
        if (pop) begin
            for (int i = 0; i < 3; i++) begin
                fifo_n[i] = fifo[i + 1];
            end
            fifo_n[3]    = '0;
            fifo_count_n = fifo_count - 3'd1;
        end
        if (push) begin
            fifo_n[fifo_count_n[1:0]] = {rd_last[1], rom_dout};
            fifo_count_n              = fifo_count_n + 3'd1;
        end
    end

    assign m_data = fifo[0].data;
    assign m_last = fifo[0].last;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            rom_addr     <= '0;
            next_addr    <= '0;
            len_q        <= '0;
            issued_count <= '0;
            rd_valid     <= '0;
            rd_last      <= '0;
            fifo_count   <= '0;
            m_valid      <= 1'b0;
            // NOTE: the tiny FIFO is reset explicitly because its head drives m_data/m_last.
            for (int i = 0; i < 4; i++) begin
                fifo[i] <= '0;
            end
        end else begin
            rd_valid   <= {rd_valid[0], issue};
            rd_last    <= {rd_last[0], issue && issue_last};
            fifo       <= fifo_n;
            fifo_count <= fifo_count_n;
            m_valid    <= (fifo_count_n != 3'd0);
            done       <= 1'b0;

            if (issue) begin
                rom_addr     <= issue_addr;
                next_addr    <= issue_addr + 1'b1;
                issued_count <= accept ? CNT_ONE : issued_count + CNT_ONE;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= length;
                        if (length == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pop && m_last) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: a behavioural ROM, directed and randomized transfers, and a
// reference model that predicts each beat as mem[(base+i) mod depth] with last on beat length-1.
module tb_rom_stream_reader;

    localparam int DW    = 36;
    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    rom_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rom [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) rom[i] = DW'(i + 32'h100);
    always @(posedge clk) rom_dout <= rom[rom_addr];

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // m_ready driver: 0 = always ready, 1 = random, 2 = fixed 7-cycle pattern 1,0,0,1,1,0,1
    int         rmode = 0;
    int         pidx  = 0;
    logic [6:0] pat   = 7'b1011001;
    always @(posedge clk) begin
        #1;
        case (rmode)
            1:       m_ready = 1'($urandom_range(0, 1));
            2:       m_ready = pat[pidx % 7];
            default: m_ready = 1'b1;
        endcase
        pidx++;
    end

    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation of the stream; k is the cycle index relative to the accepting edge T.
    int          t_start = 0;
    logic [DW:0] beats[$];
    int          first_valid_k, done_cnt, done_k, busy_cnt, busy_first, busy_last;
    int          stall_err = 0;
    int          fifo_max  = 0;
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_beat;

    always @(negedge clk) begin
        int k;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            k = cyc - t_start;
            if (prev_stall && (!m_valid || {m_last, m_data} != prev_beat)) stall_err++;
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_data};
            if (m_valid && first_valid_k < 0) first_valid_k = k;
            if (m_valid && m_ready) beats.push_back({m_last, m_data});
            if (done) begin
                done_cnt++;
                done_k = k;
            end
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            if (int'(dut.fifo_count) > fifo_max) fifo_max = int'(dut.fifo_count);
        end
    end

    task automatic clear_stats();
        beats.delete();
        first_valid_k = -1;
        done_cnt      = 0;
        done_k        = -1;
        busy_cnt      = 0;
        busy_first    = -1;
        busy_last     = -1;
        stall_err     = 0;
    endtask

    // Pulse start with (b, n), optionally re-pulse start at cycle restart_k, wait for done,
    // idle gap cycles, then compare everything observed against the reference model.
    task automatic run_xfer(input logic [AW-1:0] b, input logic [AW:0] n, input int mode,
                            input int restart_k, input int gap, input bit timing);
        int          budget;
        int          k;
        logic [DW:0] exp;
        rmode = mode;
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        length    = n;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        length    = (AW + 1)'($urandom);
        t_start   = cyc - 1;
        clear_stats();
        budget = int'(n) * 40 + 100;
        k      = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
            start = (k == restart_k);
        end
        start = 1'b0;
        check("done_seen", 64'(done_cnt > 0), 64'd1);
        repeat (gap) @(negedge clk);
        check("done_once", 64'(done_cnt), 64'd1);
        check("beat_count", 64'(beats.size()), 64'(n));
        for (int i = 0; i < beats.size(); i++) begin
            exp = {i == int'(n) - 1, DW'(((int'(b) + i) % DEPTH) + 32'h100)};
            check($sformatf("beat%0d_last_data", i), 64'(beats[i]), 64'(exp));
        end
        check("stall_stable", 64'(stall_err), 64'd0);
        if (timing) begin
            if (n == '0) begin
                check("len0_done_k", 64'(done_k), 64'd1);
                check("len0_busy", 64'(busy_cnt), 64'd0);
                check("len0_no_valid", 64'(first_valid_k), 64'(-1));
            end else begin
                check("first_valid_k", 64'(first_valid_k), 64'd3);
                check("done_k", 64'(done_k), 64'(int'(n) + 3));
                check("busy_first", 64'(busy_first), 64'd1);
                check("busy_last", 64'(busy_last), 64'(int'(n) + 2));
                check("busy_cnt", 64'(busy_cnt), 64'(int'(n) + 2));
            end
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        m_ready   = 1'b0;
        clear_stats();
        repeat (3) @(negedge clk);
        check("reset_outs", 64'({busy, done, m_valid, m_last, rom_addr, m_data}), 64'd0);
        rst = 1'b0;

        run_xfer(12'h010, 13'd4, 0, 0, 2, 1'b1);
        run_xfer(12'h010, 13'd4, 2, 0, 1, 1'b0);
        run_xfer(12'hFFE, 13'd4, 0, 0, 1, 1'b1);
        run_xfer(12'h000, 13'd0, 0, 0, 2, 1'b1);
        run_xfer(12'h100, 13'd3, 0, 0, 0, 1'b1);
        run_xfer(12'h200, 13'd5, 0, 0, 1, 1'b1);
        run_xfer(12'h030, 13'd8, 0, 4, 1, 1'b1);

        // Reset after the second beat of a length-8 transfer.
        rmode = 0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 12'h000;
        length    = 13'd8;
        @(posedge clk);
        #1;
        start   = 1'b0;
        t_start = cyc - 1;
        clear_stats();
        k = 0;
        while (beats.size() < 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_beats", 64'(beats.size()), 64'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outs", 64'({busy, done, m_valid, m_last, rom_addr, m_data}), 64'd0);
        rst = 1'b0;
        clear_stats();
        repeat (10) @(negedge clk);
        check("rst_no_done", 64'(done_cnt), 64'd0);
        check("rst_no_stale", 64'(beats.size()), 64'd0);
        run_xfer(12'h020, 13'd2, 0, 0, 1, 1'b1);

        run_xfer(12'h000, 13'd4096, 0, 0, 1, 1'b1);

        for (int t = 0; t < 25; t++) begin
            run_xfer(AW'($urandom), (AW + 1)'($urandom_range(0, 40)), 1 + (t % 2),
                     int'($urandom_range(0, 10)), int'($urandom_range(0, 2)), 1'b0);
        end

        check("fifo_max_le4", 64'(fifo_max <= 4), 64'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
